// File: rtl/exc_irq_unit.sv
// ---------------------------------------------------------------------------
// exc_irq_unit
//
// Exception / interrupt controller that sits beside the decode stage.
// It latches edge-triggered interrupt lines into pending bits, applies a
// software-writable enable mask and a fixed lowest-index-first priority, and
// arbitrates interrupts against illegal-instruction traps. When a trap is
// taken it redirects fetch and flushes decode in the same cycle, then records
// the return address (epc), the cause and the serviced line on the next edge.
// A two-state FSM (IDLE / HANDLER) tracks whether a handler is running, so
// traps cannot nest, and it implements the return-from-handler path.
//
// Parameters:
//   N_IRQ    number of external interrupt lines (1..16)
//   PC_W     program counter width
//   IRQ_VEC  fetch target for interrupts
//   EXC_VEC  fetch target for illegal instructions
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high reset
//   irq_in       in   raw interrupt request levels (already synchronised)
//   mask_we      in   mask register write enable
//   mask_wdata   in   new mask value, bit set = line enabled
//   exc_illegal  in   decoder flags the decode instruction as undefined
//   id_pc        in   PC of the instruction in decode
//   id_kernel    in   decode instruction runs in kernel mode
//   pipe_stall   in   decode stage is held this cycle
//   eret         in   decode holds a valid return-from-handler instruction
//   trap_valid   out  redirect fetch to trap_vector and flush decode (comb.)
//   trap_vector  out  IRQ_VEC or EXC_VEC (IRQ_VEC whenever no trap)
//   eret_valid   out  redirect fetch to epc (comb.)
//   epc          out  saved return address
//   cause        out  0 none, 1 interrupt, 2 illegal instruction
//   irq_id       out  index of the last serviced interrupt line
//   pending      out  pending interrupt register
//   mask         out  interrupt mask register
//   in_handler   out  FSM is in HANDLER
//   double_fault out  sticky: illegal instruction seen while in HANDLER
// ---------------------------------------------------------------------------
module exc_irq_unit #(
  parameter int              N_IRQ   = 4,
  parameter int              PC_W    = 32,
  parameter logic [PC_W-1:0] IRQ_VEC = 32'h80000004,
  parameter logic [PC_W-1:0] EXC_VEC = 32'h80000008
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             exc_illegal,
  input  logic [PC_W-1:0]  id_pc,
  input  logic             id_kernel,
  input  logic             pipe_stall,
  input  logic             eret,
  output logic             trap_valid,
  output logic [PC_W-1:0]  trap_vector,
  output logic             eret_valid,
  output logic [PC_W-1:0]  epc,
  output logic [1:0]       cause,
  output logic [3:0]       irq_id,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask,
  output logic             in_handler,
  output logic             double_fault
);

  // Cause encodings as they appear on the cause output.
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_IRQ     = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;

  typedef enum logic {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t           state;
  logic [N_IRQ-1:0] irq_d;

  logic [N_IRQ-1:0] irq_rise;
  logic [N_IRQ-1:0] masked;
  logic [N_IRQ-1:0] grant;
  logic [3:0]       irq_sel;
  logic             irq_hit;
  logic             eligible;
  logic             take_exc;
  logic             take_irq;
  logic             take_eret;
  logic             illegal_in_handler;
  logic [N_IRQ-1:0] pending_next;

  // Rising edges are detected against the previous-cycle sample. The delay
  // register resets to 0, so a line that is already high when reset
  // releases is seen as a fresh edge on the first clock afterwards.
  assign irq_rise = irq_in & ~irq_d;

  // The current (old) mask is used here, so a mask write only affects
  // arbitration from the cycle after the write.
  assign masked = pending & mask;

  // Fixed priority: lowest index wins. Iterating from the top down lets the
  // lowest set bit overwrite any higher one.
  always_comb begin
    irq_sel = 4'd0;
    grant   = '0;
    irq_hit = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) begin
        irq_sel  = 4'(i);
        grant    = '0;
        grant[i] = 1'b1;
        irq_hit  = 1'b1;
      end
    end
  end

  // Traps are only considered from user-mode code in an unstalled decode
  // slot while no handler is running. Illegal instruction beats interrupts.
  assign eligible = (state == IDLE) && !pipe_stall && !id_kernel;
  assign take_exc = eligible && exc_illegal;
  assign take_irq = eligible && !exc_illegal && irq_hit;

  assign take_eret          = (state == HANDLER) && eret && !pipe_stall;
  assign illegal_in_handler = (state == HANDLER) && exc_illegal && !pipe_stall;

  assign trap_valid  = take_exc || take_irq;
  assign trap_vector = take_exc ? EXC_VEC : IRQ_VEC;
  assign eret_valid  = take_eret;
  assign in_handler  = (state == HANDLER);

  // Clear the serviced line, then OR in new edges so a coincident new edge
  // on the same line survives the clear.
  always_comb begin
    pending_next = pending;
    if (take_irq) begin
      pending_next = pending_next & ~grant;
    end
    pending_next = pending_next | irq_rise;
  end

  // All architectural state: FSM, trap record, pending/mask registers and
  // the sticky double-fault flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      irq_d        <= '0;
      pending      <= '0;
      mask         <= '0;
      epc          <= '0;
      cause        <= CAUSE_NONE;
      irq_id       <= 4'd0;
      double_fault <= 1'b0;
    end else begin
      irq_d   <= irq_in;
      pending <= pending_next;

      if (mask_we) begin
        mask <= mask_wdata;
      end

      unique case (state)
        IDLE: begin
          if (take_exc) begin
            state <= HANDLER;
            cause <= CAUSE_ILLEGAL;
            // Skip the offending instruction on return.
            epc   <= id_pc + PC_W'(4);
          end else if (take_irq) begin
            state  <= HANDLER;
            cause  <= CAUSE_IRQ;
            irq_id <= irq_sel;
            // Re-execute the interrupted instruction on return.
            epc    <= id_pc;
          end
        end
        HANDLER: begin
          if (illegal_in_handler) begin
            double_fault <= 1'b1;
          end
          if (take_eret) begin
            state <= IDLE;
            cause <= CAUSE_NONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_irq_unit.sv
// ---------------------------------------------------------------------------
// tb_exc_irq_unit
//
// Directed bench for exc_irq_unit. Each vector drives one cycle of inputs and
// carries the hand-computed outputs expected during that cycle. The driver
// pushes those expectations, tagged with the cycle number, into a queue; an
// independent monitor pops and compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_exc_irq_unit;

  localparam int          N_IRQ   = 4;
  localparam int          PC_W    = 32;
  localparam logic [31:0] IRQ_VEC = 32'h80000004;
  localparam logic [31:0] EXC_VEC = 32'h80000008;

  logic             clk;
  logic             reset;
  logic [N_IRQ-1:0] irq_in;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             exc_illegal;
  logic [PC_W-1:0]  id_pc;
  logic             id_kernel;
  logic             pipe_stall;
  logic             eret;
  logic             trap_valid;
  logic [PC_W-1:0]  trap_vector;
  logic             eret_valid;
  logic [PC_W-1:0]  epc;
  logic [1:0]       cause;
  logic [3:0]       irq_id;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic             in_handler;
  logic             double_fault;

  typedef struct {
    int          cyc;
    string       name;
    logic        tv;
    logic [31:0] tvec;
    logic        ev;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic [3:0]  id;
    logic [3:0]  pend;
    logic [3:0]  mask;
    logic        inh;
    logic        df;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   vectors;
  int   miscompares;

  exc_irq_unit #(
    .N_IRQ  (N_IRQ),
    .PC_W   (PC_W),
    .IRQ_VEC(IRQ_VEC),
    .EXC_VEC(EXC_VEC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .exc_illegal (exc_illegal),
    .id_pc       (id_pc),
    .id_kernel   (id_kernel),
    .pipe_stall  (pipe_stall),
    .eret        (eret),
    .trap_valid  (trap_valid),
    .trap_vector (trap_vector),
    .eret_valid  (eret_valid),
    .epc         (epc),
    .cause       (cause),
    .irq_id      (irq_id),
    .pending     (pending),
    .mask        (mask),
    .in_handler  (in_handler),
    .double_fault(double_fault)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter shared by driver and monitor to line up expectations.
  initial cyc = 0;
  always @(posedge clk) cyc++;

  // Compare one expectation against what the DUT presents right now.
  task automatic checkOutput(input exp_t e);
    vectors++;
    if ({trap_valid, trap_vector, eret_valid, epc, cause, irq_id, pending,
         mask, in_handler, double_fault} !==
        {e.tv, e.tvec, e.ev, e.epc, e.cause, e.id, e.pend, e.mask, e.inh, e.df}) begin
      miscompares++;
      $display("[TB] FAIL %s cyc=%0d got tv=%b vec=%h ev=%b epc=%h cause=%0d id=%0d pend=%b mask=%b inh=%b df=%b, expected tv=%b vec=%h ev=%b epc=%h cause=%0d id=%0d pend=%b mask=%b inh=%b df=%b",
               e.name, cyc, trap_valid, trap_vector, eret_valid, epc, cause, irq_id,
               pending, mask, in_handler, double_fault, e.tv, e.tvec, e.ev, e.epc,
               e.cause, e.id, e.pend, e.mask, e.inh, e.df);
    end
  endtask

  // Monitor: on each falling edge, consume every expectation due this cycle.
  // An expectation whose cycle has already passed was never checked and is
  // reported as a miscompare.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc == cyc) begin
        checkOutput(e);
      end else begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s missed check: due cyc %0d, now %0d", e.name, e.cyc, cyc);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge and, when chk is
  // set, queue the outputs expected during that cycle.
  task automatic applyStimulus(
    input string       name,
    input bit          chk,
    input logic        rst,
    input logic [3:0]  irq,
    input logic        mwe,
    input logic [3:0]  mwd,
    input logic        ill,
    input logic [31:0] pc,
    input logic        kern,
    input logic        stall,
    input logic        er,
    input logic        x_tv,
    input logic [31:0] x_tvec,
    input logic        x_ev,
    input logic [31:0] x_epc,
    input logic [1:0]  x_cause,
    input logic [3:0]  x_id,
    input logic [3:0]  x_pend,
    input logic [3:0]  x_mask,
    input logic        x_inh,
    input logic        x_df);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = rst;
    irq_in      = irq;
    mask_we     = mwe;
    mask_wdata  = mwd;
    exc_illegal = ill;
    id_pc       = pc;
    id_kernel   = kern;
    pipe_stall  = stall;
    eret        = er;
    if (chk) begin
      e.cyc   = cyc;
      e.name  = name;
      e.tv    = x_tv;
      e.tvec  = x_tvec;
      e.ev    = x_ev;
      e.epc   = x_epc;
      e.cause = x_cause;
      e.id    = x_id;
      e.pend  = x_pend;
      e.mask  = x_mask;
      e.inh   = x_inh;
      e.df    = x_df;
      exp_q.push_back(e);
    end
  endtask

  // Directed sequence. Columns: name, chk, rst, irq, mwe, mwd, ill, pc, kern,
  // stall, eret | tv, vec, ev, epc, cause, id, pend, mask, inh, df.
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    irq_in      = '0;
    mask_we     = 1'b0;
    mask_wdata  = '0;
    exc_illegal = 1'b0;
    id_pc       = '0;
    id_kernel   = 1'b0;
    pipe_stall  = 1'b0;
    eret        = 1'b0;

    // Reset and mask setup, then a single interrupt on line 2.
    applyStimulus("rst0",        0, 1, 4'b0000, 0, 4'h0, 0, 32'h0,        0, 0, 0,  0, IRQ_VEC, 0, 32'h0,        0, 0, 4'b0000, 4'b0000, 0, 0);
    applyStimulus("reset_state", 1, 1, 4'b0000, 0, 4'h0, 0, 32'h0,        0, 0, 0,  0, IRQ_VEC, 0, 32'h0,        0, 0, 4'b0000, 4'b0000, 0, 0);
    applyStimulus("mask_write",  1, 0, 4'b0000, 1, 4'hF, 0, 32'h00400010, 0, 0, 0,  0, IRQ_VEC, 0, 32'h0,        0, 0, 4'b0000, 4'b0000, 0, 0);
    applyStimulus("mask_set",    1, 0, 4'b0000, 0, 4'h0, 0, 32'h00400010, 0, 0, 0,  0, IRQ_VEC, 0, 32'h0,        0, 0, 4'b0000, 4'b1111, 0, 0);
    applyStimulus("irq2_edge",   1, 0, 4'b0100, 0, 4'h0, 0, 32'h00400010, 0, 0, 0,  0, IRQ_VEC, 0, 32'h0,        0, 0, 4'b0000, 4'b1111, 0, 0);
    applyStimulus("irq2_trap",   1, 0, 4'b0000, 0, 4'h0, 0, 32'h00400010, 0, 0, 0,  1, IRQ_VEC, 0, 32'h0,        0, 0, 4'b0100, 4'b1111, 0, 0);
    applyStimulus("irq2_record", 1, 0, 4'b0000, 0, 4'h0, 0, 32'h00400014, 0, 0, 0,  0, IRQ_VEC, 0, 32'h00400010, 1, 2, 4'b0000, 4'b1111, 1, 0);
    applyStimulus("eret1",       1, 0, 4'b0000, 0, 4'h0, 0, 32'h00400014, 0, 0, 1,  0, IRQ_VEC, 1, 32'h00400010, 1, 2, 4'b0000, 4'b1111, 1, 0);

    // Line 0 pends under kernel mode, then illegal beats it.
    applyStimulus("kern_pend0",  1, 0, 4'b0001, 0, 4'h0, 0, 32'h00400018, 1, 0, 0,  0, IRQ_VEC, 0, 32'h00400010, 0, 2, 4'b0000, 4'b1111, 0, 0);
    applyStimulus("ill_wins",    1, 0, 4'b0001, 0, 4'h0, 1, 32'h00400020, 0, 0, 0,  1, EXC_VEC, 0, 32'h00400010, 0, 2, 4'b0001, 4'b1111, 0, 0);
    applyStimulus("ill_record",  1, 0, 4'b0001, 0, 4'h0, 0, 32'h00400024, 0, 0, 0,  0, IRQ_VEC, 0, 32'h00400024, 2, 2, 4'b0001, 4'b1111, 1, 0);

    // Stalled eret, then back-to-back service of line 0.
    applyStimulus("eret_stall1", 1, 0, 4'b0001, 0, 4'h0, 0, 32'h00400024, 0, 1, 1,  0, IRQ_VEC, 0, 32'h00400024, 2, 2, 4'b0001, 4'b1111, 1, 0);
    applyStimulus("eret_stall2", 1, 0, 4'b0001, 0, 4'h0, 0, 32'h00400024, 0, 1, 1,  0, IRQ_VEC, 0, 32'h00400024, 2, 2, 4'b0001, 4'b1111, 1, 0);
    applyStimulus("eret_go",     1, 0, 4'b0001, 0, 4'h0, 0, 32'h00400024, 0, 0, 1,  0, IRQ_VEC, 1, 32'h00400024, 2, 2, 4'b0001, 4'b1111, 1, 0);
    applyStimulus("b2b_trap",    1, 0, 4'b0001, 0, 4'h0, 0, 32'h00400030, 0, 0, 0,  1, IRQ_VEC, 0, 32'h00400024, 0, 2, 4'b0001, 4'b1111, 0, 0);
    applyStimulus("b2b_record",  1, 0, 4'b0000, 0, 4'h0, 0, 32'h00400034, 0, 0, 0,  0, IRQ_VEC, 0, 32'h00400030, 1, 0, 4'b0000, 4'b1111, 1, 0);
    applyStimulus("eret2",       1, 0, 4'b0000, 0, 4'h0, 0, 32'h00400034, 0, 0, 1,  0, IRQ_VEC, 1, 32'h00400030, 1, 0, 4'b0000, 4'b1111, 1, 0);

    // Masked line pends without trapping; mask write takes effect next cycle.
    applyStimulus("mask_clear",  1, 0, 4'b0000, 1, 4'h0, 0, 32'h00400038, 0, 0, 0,  0, IRQ_VEC, 0, 32'h00400030, 0, 0, 4'b0000, 4'b1111, 0, 0);
    applyStimulus("irq3_edge",   1, 0, 4'b1000, 0, 4'h0, 0, 32'h00400038, 0, 0, 0,  0, IRQ_VEC, 0, 32'h00400030, 0, 0, 4'b0000, 4'b0000, 0, 0);
    applyStimulus("mask_wr_cyc", 1, 0, 4'b1000, 1, 4'h8, 0, 32'h00400040, 0, 0, 0,  0, IRQ_VEC, 0, 32'h00400030, 0, 0, 4'b1000, 4'b0000, 0, 0);
    applyStimulus("irq3_trap",   1, 0, 4'b0000, 0, 4'h0, 0, 32'h00400040, 0, 0, 0,  1, IRQ_VEC, 0, 32'h00400030, 0, 0, 4'b1000, 4'b1000, 0, 0);
    applyStimulus("irq3_record", 1, 0, 4'b0000, 0, 4'h0, 0, 32'h00400044, 0, 0, 0,  0, IRQ_VEC, 0, 32'h00400040, 1, 3, 4'b0000, 4'b1000, 1, 0);
    applyStimulus("eret3",       1, 0, 4'b0000, 0, 4'h0, 0, 32'h00400044, 0, 0, 1,  0, IRQ_VEC, 1, 32'h00400040, 1, 3, 4'b0000, 4'b1000, 1, 0);

    // Kernel mode blocks both interrupt and illegal; then double fault.
    applyStimulus("kern_edge",   1, 0, 4'b1000, 0, 4'h0, 0, 32'h00400048, 1, 0, 0,  0, IRQ_VEC, 0, 32'h00400040, 0, 3, 4'b0000, 4'b1000, 0, 0);
    applyStimulus("kern_block",  1, 0, 4'b1000, 0, 4'h0, 1, 32'h00400048, 1, 0, 0,  0, IRQ_VEC, 0, 32'h00400040, 0, 3, 4'b1000, 4'b1000, 0, 0);
    applyStimulus("user_ill",    1, 0, 4'b1000, 0, 4'h0, 1, 32'h00400050, 0, 0, 0,  1, EXC_VEC, 0, 32'h00400040, 0, 3, 4'b1000, 4'b1000, 0, 0);
    applyStimulus("ill_in_hnd",  1, 0, 4'b1000, 0, 4'h0, 1, 32'h00400054, 0, 0, 0,  0, IRQ_VEC, 0, 32'h00400054, 2, 3, 4'b1000, 4'b1000, 1, 0);
    applyStimulus("df_sticky",   1, 0, 4'b0110, 0, 4'h0, 0, 32'h00400054, 0, 0, 0,  0, IRQ_VEC, 0, 32'h00400054, 2, 3, 4'b1000, 4'b1000, 1, 1);

    // Reset while in HANDLER with lines held high through reset.
    applyStimulus("rst_in_hnd",  1, 1, 4'b0110, 0, 4'h0, 0, 32'h00400054, 0, 0, 0,  0, IRQ_VEC, 0, 32'h00400054, 2, 3, 4'b1110, 4'b1000, 1, 1);
    applyStimulus("post_rst",    1, 0, 4'b0110, 0, 4'h0, 0, 32'h00400060, 0, 0, 0,  0, IRQ_VEC, 0, 32'h0,        0, 0, 4'b0000, 4'b0000, 0, 0);
    applyStimulus("held_pend",   1, 0, 4'b0110, 0, 4'h0, 0, 32'h00400060, 0, 0, 0,  0, IRQ_VEC, 0, 32'h0,        0, 0, 4'b0110, 4'b0000, 0, 0);
    applyStimulus("mask_line1",  1, 0, 4'b0110, 1, 4'h2, 0, 32'h00400060, 0, 0, 0,  0, IRQ_VEC, 0, 32'h0,        0, 0, 4'b0110, 4'b0000, 0, 0);
    applyStimulus("irq1_trap",   1, 0, 4'b0000, 0, 4'h0, 0, 32'h00400060, 0, 0, 0,  1, IRQ_VEC, 0, 32'h0,        0, 0, 4'b0110, 4'b0010, 0, 0);
    applyStimulus("irq1_record", 1, 0, 4'b0000, 0, 4'h0, 0, 32'h00400064, 0, 0, 0,  0, IRQ_VEC, 0, 32'h00400060, 1, 1, 4'b0100, 4'b0010, 1, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
